arithmetic_fu_pipe: RTL
=======================

ARITHMETIC_FU_PIPE -- requirements
Module: arithmetic_fu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter ROB_SIZE, default 256, ROB entries; tag width $clog2(ROB_SIZE).
REQ-003 SHALL have parameter PHYS_REG_SIZE, default 256, physical registers; tag width $clog2(PHYS_REG_SIZE).
REQ-004 SHALL have parameter UOP_SIZE, default 16, uop space; uop width $clog2(UOP_SIZE).
REQ-005 SHALL have parameter STAGES, default 2, pipeline depth, legal range 1..4.
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill all in-flight ops
- valid_in  in  1  issue valid
- ready_in  out  1  FU can accept this cycle
- uop  in  $clog2(UOP_SIZE)  operation
- rob_entry_in  in  $clog2(ROB_SIZE)  ROB tag
- dest_reg_in  in  $clog2(PHYS_REG_SIZE)  dest tag
- rs1, rs2, pc  in  XLEN each  operands; rs2 carries immediate for LUI/AUIPC
- valid_out  out  1  result valid
- ready_out  in  1  writeback accepts result
- result  out  XLEN  computed value
- illegal_out  out  1  uop not supported
- rob_entry  out  $clog2(ROB_SIZE)  tag of result
- dest_reg  out  $clog2(PHYS_REG_SIZE)  dest of result
- inflight  out  3  valid ops held in pipeline

Function
REQ-007 SHALL decode uop: 0 ADD rs1+rs2; 1 SUB rs1-rs2; 2 SLT ($signed(rs1)<$signed(rs2)); 3 SLTU (rs1<rs2 unsigned); 4 LUI rs2; 5 AUIPC pc+rs2; others illegal.
REQ-008 SHALL compute mod 2^XLEN, no overflow flag; SLT/SLTU results zero-extended 0/1.
REQ-009 SHALL for illegal uop produce result 0, illegal_out 1, still flow through pipeline with its tags.
REQ-010 SHALL hold STAGES registered stages, each: valid, result, illegal, rob tag, dest tag; compute combinationally into stage 1, later stages pure transport.
REQ-011 SHALL present last stage on outputs; valid_out = last-stage valid.
REQ-012 SHALL advance stage i when stage i empty or stage i+1 (or output handshake for last stage) advancing; ready_in = stage 1 advancing.
REQ-013 SHALL accept op iff valid_in && ready_in; output transfer iff valid_out && ready_out.
REQ-014 SHALL give latency exactly STAGES cycles acceptance-to-valid_out absent stalls; sustain 1 op/cycle with ready_out held 1.
REQ-015 SHALL hold last stage and all outputs stable while valid_out && !ready_out; fill empty upstream stages (bubble collapse) and deassert ready_in only when all STAGES full.
REQ-016 SHALL keep result, illegal_out, tags at 0 when valid_out is 0.
REQ-017 SHALL on flush clear all stage valids next cycle, drop any op presented that cycle, ignore ready_out; ready_in SHALL be 1 the cycle after.
REQ-018 SHALL maintain inflight = count of valid stages, range 0..STAGES, updated same edge as stages.
REQ-019 SHALL preserve issue order; no reordering or duplication.

Reset
REQ-020 SHALL on rst clear all stage valids and payloads: valid_out 0, result 0, illegal_out 0, rob_entry 0, dest_reg 0, inflight 0, ready_in 1 next cycle.
REQ-021 SHALL give rst priority over flush and valid_in; rst mid-operation discards all in-flight ops.

Verification
REQ-022 Streaming, STAGES=2: ADD 5+7 tag 3, then SUB 5-7 tag 4 back-to-back, ready_out=1 -> valid_out cycles 2 and 3, results 12 then 0xFFFFFFFE, rob_entry 3 then 4.
REQ-023 Compare: SLT rs1=0xFFFFFFFF rs2=1 -> 1; SLTU same -> 0; AUIPC pc=0x1000 rs2=0x2000 -> 0x3000; uop 9 -> result 0, illegal_out 1.
REQ-024 Backpressure: ready_out=0, issue 3 ops with STAGES=2 -> ready_in 0 after 2 accepted, inflight 2, outputs frozen; release ready_out -> ops drain in order, third accepted.
REQ-025 Flush: 2 ops in flight plus valid_in on flush cycle -> next cycle valid_out 0, inflight 0, no stale result ever appears.
REQ-026 Reset mid-stream: rst asserted with valid_out=1, ready_out=0 -> next cycle all outputs 0, inflight 0, ready_in 1.
REQ-027 Random stress, STAGES 1..4, random valid_in/ready_out/flush vs reference model -> results, tags, order match, no loss or duplication.

Source files
------------

// File: rtl/arithmetic_fu_pipe.sv
// ---------------------------------------------------------------------------
// arithmetic_fu_pipe
//
// Purpose:
//   Pipelined integer arithmetic functional unit for an out-of-order core.
//   Executes ADD, SUB, SLT, SLTU, LUI and AUIPC. Any other uop is flagged
//   illegal and still travels through the pipe carrying its ROB and
//   destination tags, so the ROB can raise the exception in order.
//   The result is computed combinationally into stage 1. Stages 2..STAGES
//   only move data along. Backpressure from writeback stalls the last stage.
//   Empty upstream stages keep filling (bubble collapse), so ready_in only
//   drops when every stage holds a valid op.
//
// Parameters:
//   XLEN           datapath width
//   ROB_SIZE       ROB entries          (tag width $clog2(ROB_SIZE))
//   PHYS_REG_SIZE  physical registers   (tag width $clog2(PHYS_REG_SIZE))
//   UOP_SIZE       uop encoding space   (uop width $clog2(UOP_SIZE))
//   STAGES         pipeline depth, 1..4
//
// Ports:
//   clk           single clock, all state updates on the rising edge
//   rst           synchronous active-high reset, beats flush and valid_in
//   flush         kills every in-flight op and the op issued this cycle
//   valid_in      issue request
//   ready_in      FU can accept an op this cycle
//   uop           operation select
//   rob_entry_in  ROB tag of the issued op
//   dest_reg_in   physical destination tag of the issued op
//   rs1, rs2, pc  operands (rs2 carries the immediate for LUI/AUIPC)
//   valid_out     result valid (last stage valid)
//   ready_out     writeback accepts the result this cycle
//   result        computed value, 0 when valid_out is 0
//   illegal_out   uop not supported, 0 when valid_out is 0
//   rob_entry     ROB tag of the result, 0 when valid_out is 0
//   dest_reg      destination tag of the result, 0 when valid_out is 0
//   inflight      number of valid stages, 0..STAGES
// ---------------------------------------------------------------------------
module arithmetic_fu_pipe #(
    parameter int XLEN          = 32,
    parameter int ROB_SIZE      = 256,
    parameter int PHYS_REG_SIZE = 256,
    parameter int UOP_SIZE      = 16,
    parameter int STAGES        = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             valid_in,
    output logic                             ready_in,
    input  logic [$clog2(UOP_SIZE)-1:0]      uop,
    input  logic [$clog2(ROB_SIZE)-1:0]      rob_entry_in,
    input  logic [$clog2(PHYS_REG_SIZE)-1:0] dest_reg_in,
    input  logic [XLEN-1:0]                  rs1,
    input  logic [XLEN-1:0]                  rs2,
    input  logic [XLEN-1:0]                  pc,
    output logic                             valid_out,
    input  logic                             ready_out,
    output logic [XLEN-1:0]                  result,
    output logic                             illegal_out,
    output logic [$clog2(ROB_SIZE)-1:0]      rob_entry,
    output logic [$clog2(PHYS_REG_SIZE)-1:0] dest_reg,
    output logic [2:0]                       inflight
);

    localparam int UOP_W  = $clog2(UOP_SIZE);
    localparam int ROB_W  = $clog2(ROB_SIZE);
    localparam int PREG_W = $clog2(PHYS_REG_SIZE);

    localparam logic [UOP_W-1:0] UOP_ADD   = UOP_W'(0);
    localparam logic [UOP_W-1:0] UOP_SUB   = UOP_W'(1);
    localparam logic [UOP_W-1:0] UOP_SLT   = UOP_W'(2);
    localparam logic [UOP_W-1:0] UOP_SLTU  = UOP_W'(3);
    localparam logic [UOP_W-1:0] UOP_LUI   = UOP_W'(4);
    localparam logic [UOP_W-1:0] UOP_AUIPC = UOP_W'(5);

    // Stage storage. Index 0 is stage 1 (compute), index STAGES-1 drives
    // the outputs. Payload fields are kept at zero whenever valid is 0.
    logic [STAGES-1:0] st_valid;
    logic [XLEN-1:0]   st_result  [STAGES];
    logic              st_illegal [STAGES];
    logic [ROB_W-1:0]  st_rob     [STAGES];
    logic [PREG_W-1:0] st_dest    [STAGES];

    logic [STAGES-1:0] advance;
    logic              accept;
    logic [XLEN-1:0]   calc_result;
    logic              calc_illegal;

    // Decode and execute the issued op. Arithmetic wraps mod 2^XLEN and
    // the compares return a zero-extended 0/1. Unsupported uops give 0 and
    // raise the illegal flag.
    always_comb begin
        calc_result  = '0;
        calc_illegal = 1'b0;
        case (uop)
            UOP_ADD:   calc_result = rs1 + rs2;
            UOP_SUB:   calc_result = rs1 - rs2;
            UOP_SLT:   calc_result = XLEN'($signed(rs1) < $signed(rs2));
            UOP_SLTU:  calc_result = XLEN'(rs1 < rs2);
            UOP_LUI:   calc_result = rs2;
            UOP_AUIPC: calc_result = pc + rs2;
            default: begin
                calc_result  = '0;
                calc_illegal = 1'b1;
            end
        endcase
    end

    // A stage may take new contents when it is empty or the stage after it
    // is moving too. Unrolled, that means stage i advances when writeback
    // is ready or any stage from i to the end is empty. Writing it in that
    // closed form avoids a combinational chain through the advance vector.
    always_comb begin
        logic all_full;
        advance  = '0;
        all_full = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            all_full = 1'b1;
            for (int j = 0; j < STAGES; j++) begin
                if (j >= i) begin
                    all_full = all_full & st_valid[j];
                end
            end
            advance[i] = ready_out | ~all_full;
        end
    end

    assign ready_in = advance[0];
    assign accept   = valid_in & ready_in;

    // Pipeline registers. Reset and flush both empty every stage and zero
    // the payloads; reset is tested first so it wins. Otherwise each
    // advancing stage copies its predecessor (which is already zero when
    // empty), and stage 1 loads the freshly computed op or a clean bubble.
    // A stalled stage simply holds, which freezes the outputs.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            st_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                st_result[i]  <= '0;
                st_illegal[i] <= 1'b0;
                st_rob[i]     <= '0;
                st_dest[i]    <= '0;
            end
        end else begin
            for (int i = STAGES - 1; i >= 1; i--) begin
                if (advance[i]) begin
                    st_valid[i]   <= st_valid[i-1];
                    st_result[i]  <= st_result[i-1];
                    st_illegal[i] <= st_illegal[i-1];
                    st_rob[i]     <= st_rob[i-1];
                    st_dest[i]    <= st_dest[i-1];
                end
            end
            if (advance[0]) begin
                if (accept) begin
                    st_valid[0]   <= 1'b1;
                    st_result[0]  <= calc_result;
                    st_illegal[0] <= calc_illegal;
                    st_rob[0]     <= rob_entry_in;
                    st_dest[0]    <= dest_reg_in;
                end else begin
                    st_valid[0]   <= 1'b0;
                    st_result[0]  <= '0;
                    st_illegal[0] <= 1'b0;
                    st_rob[0]     <= '0;
                    st_dest[0]    <= '0;
                end
            end
        end
    end

    // Occupancy is derived straight from the stage valids, so it changes
    // on the same edge as the stages themselves.
    always_comb begin
        inflight = 3'd0;
        for (int i = 0; i < STAGES; i++) begin
            if (st_valid[i]) begin
                inflight = inflight + 3'd1;
            end
        end
    end

    // The last stage is the output port.
    assign valid_out   = st_valid[STAGES-1];
    assign result      = st_result[STAGES-1];
    assign illegal_out = st_illegal[STAGES-1];
    assign rob_entry   = st_rob[STAGES-1];
    assign dest_reg    = st_dest[STAGES-1];

endmodule
